serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 136 +++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell used by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per enabled cycle, LSB first, result in d/bout.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enable,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_e        state_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic          br_r;
    logic [CW-1:0] cnt_r;
    logic          diff_s;
    logic          borrow_s;

    // Operands are shifted right so the active bit is always at index 0.
    full_subtractor u_cell (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (br_r),
        .diff (diff_s),
        .bout (borrow_s)
    );

    // Control FSM and datapath registers; enable gates every SHIFT update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            d       <= {N{1'b0}};
            bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && enable) begin
                        a_r     <= a;
                        b_r     <= b;
                        br_r    <= bin;
                        cnt_r   <= {CW{1'b0}};
                        d       <= {N{1'b0}};
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        d    <= {diff_s, d[N-1:1]};
                        a_r  <= {1'b0, a_r[N-1:1]};
                        b_r  <= {1'b0, b_r[N-1:1]};
                        br_r <= borrow_s;
                        if (cnt_r == LAST_BIT) begin
                            bout    <= borrow_s;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor (N=4).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       bin = 1'b0;
    logic [3:0] d;
    logic       bout;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] exp_q[$];

    serial_subtractor #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .enable (enable),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .d      (d),
        .bout   (bout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one operation; optional stall window, mid-op start pulse, or mid-op reset.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                          input int stall_at, input int stall_len, input int restart_at,
                          input int abort_at, input int exp_cyc, input string tag);
        int cyc;
        bit seen;
        logic [4:0] e;
        logic [4:0] ex;
        ex = {1'b0, ta} - {1'b0, tb} - {4'd0, tbin};
        exp_q.push_back(ex);
        a = ta; b = tb; bin = tbin; start = 1'b1; enable = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (start) begin
                a = 4'd1; b = 4'd1; bin = 1'b0;
            end
            if (cyc == stall_at) enable = 1'b0;
            if (cyc == stall_at + stall_len) enable = 1'b1;
            if (cyc == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                check({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
                check({tag, "_abort_d"}, {28'd0, d}, 32'd0);
                check({tag, "_abort_bout"}, {31'd0, bout}, 32'd0);
                check({tag, "_abort_done"}, {31'd0, done}, 32'd0);
                void'(exp_q.pop_back());
                return;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, cyc, exp_cyc);
        e = exp_q.pop_front();
        check({tag, "_d"}, {28'd0, d}, {28'd0, e[3:0]});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, e[4]});
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_d_hold"}, {28'd0, d}, {28'd0, e[3:0]});
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_d", {28'd0, d}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // start ignored while enable is low
        a = 4'd5; b = 4'd2; start = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_en0_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        enable = 1'b1;

        run_op(4'd9, 4'd3, 1'b0, -1, 0, -1, -1, 5, "basic");
        run_op(4'd3, 4'd9, 1'b0, -1, 0, -1, -1, 5, "neg");
        run_op(4'd0, 4'd0, 1'b1, -1, 0, -1, -1, 5, "binonly");
        run_op(4'd9, 4'd3, 1'b0, 3, 2, -1, -1, 7, "stall");
        run_op(4'd9, 4'd3, 1'b0, -1, 0, 2, -1, 5, "restart");

        // No done without a fresh start
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_extra_done", {31'd0, done}, 32'd0);
        end

        run_op(4'd12, 4'd5, 1'b0, -1, 0, -1, 2, 5, "abort");
        run_op(4'd15, 4'd15, 1'b1, -1, 0, -1, -1, 5, "after_rst");

        for (int i = 0; i < 6; i++) begin
            run_op(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), -1, 0, -1, -1, 5, "rand");
        end
        run_op(4'd15, 4'd0, 1'b0, -1, 0, -1, -1, 5, "max");
        run_op(4'd0, 4'd15, 1'b1, -1, 0, -1, -1, 5, "min");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
